stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//  Shares the single edge-triggered Stack (push/pop strobes, 8-bit d_in/d_out) between two requesters.
//  Typical requesters: datapath operand unit (req 0) and call/return unit (req 1).
//  Converts valid/done requests into clean single-cycle push/pop strobes separated by a low cycle.
//  Tracks occupancy, rejects overflow/underflow, returns popped data, and supports a flush that drains the stack.
// PARAMETERS
//  DATA_W  8     data width; must match the Stack word
//  DEPTH   1024  Stack array size; slot 0 is never written, so usable capacity = DEPTH-1
//  CNT_W   10    occupancy counter width = $clog2(DEPTH)
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous, active-high reset
//  req_valid   in   2          per-requester request; held high until matching done bit pulses
//  req_op      in   2          per-requester op: 0=push, 1=pop; stable while valid
//  req_data    in   2*DATA_W   push data; requester i uses bits [i*DATA_W +: DATA_W]; stable while valid
//  done        out  2          one-cycle completion pulse, one bit per requester
//  rsp_data    out  DATA_W     popped word (pop) or 0 (push); valid only while done!=0
//  rsp_err     out  1          high with done when the op was rejected (push-full / pop-empty)
//  flush       in   1          one-cycle pulse: drain the stack to empty
//  busy        out  1          high in every state except IDLE
//  count       out  CNT_W      current occupancy, 0..DEPTH-1
//  full        out  1          count == DEPTH-1
//  empty       out  1          count == 0
//  stk_push    out  1          to Stack.push; registered
//  stk_pop     out  1          to Stack.pop; registered
//  stk_d_in    out  DATA_W     to Stack.d_in; registered, held stable across the strobe
//  stk_d_out   in   DATA_W     from Stack.d_out (combinational top of stack)
// BEHAVIOUR
//  Reset values: done=0, rsp_data=0, rsp_err=0, stk_push=0, stk_pop=0, stk_d_in=0, count=0, busy=0, last_grant=1, state=IDLE.
//  All outputs are registered.
//  State machine: IDLE, STROBE, RESP, F_STROBE, F_GAP.
//  IDLE:
//   - flush=1: go to F_STROBE (or RESP-less stay IDLE if empty); flush has priority over requests.
//   - Else grant one valid requester, round-robin:
//     - both valid -> grant the index != last_grant, then set last_grant = granted index;
//     - one valid -> grant it.
//   - On grant, latch id, op, data; stk_d_in <= req data; latch top = stk_d_out.
//   - Illegal op (push while full, pop while empty) -> RESP with err=1; no strobe, count unchanged.
//   - Legal op -> STROBE.
//  STROBE (1 cycle):
//   - stk_push or stk_pop = 1 per op.
//   - count +1 on push, -1 on pop.
//   - Next state: RESP.
//  RESP (1 cycle):
//   - Strobes 0; done[id]=1; rsp_err per check.
//   - rsp_data = latched top on a legal pop, else 0.
//   - Next state: IDLE.
//   - The requester drops valid (or presents its next op) in the cycle after done.
//  Latency: grant edge to done = 2 cycles; max throughput one op per 3 cycles.
//   Strobe high 1 cycle, low >= 2 cycles between strobes.
//  Flush:
//   - F_STROBE: stk_pop=1, count-1.
//   - F_GAP: strobe 0; if count==0 -> IDLE, else -> F_STROBE.
//   - Requests are ignored (not granted, no done) during flush; flush pulses while busy are ignored.
//  Boundaries:
//   - count saturates by rejection only; it never wraps.
//   - Push at count=DEPTH-2 is legal and sets full.
//   - A requester whose valid drops before done is a protocol violation (undefined).
//  Reset mid-operation: strobes drop at the reset edge, no done is issued, count=0.
//   The Stack has no reset, so system reset must be applied with the Stack already empty,
//   or followed by re-initialisation of the Stack.
// TESTING
//  1. Reset, req0 push 0xA5 -> stk_push pulses 1 cycle with stk_d_in=0xA5; done[0] 2 cycles after grant; count=1, rsp_err=0.
//  2. Push 0x11, 0x22, then req1 pop -> rsp_data=0x22, count=1; pop again -> 0x11, empty=1.
//  3. Pop when empty -> done with rsp_err=1, rsp_data=0, no stk_pop pulse, count stays 0.
//  4. req0 and req1 valid together, repeated -> grants 0,1,0,1; the loser waits with no done.
//  5. Fill to count=1023 -> full=1; a further push returns rsp_err=1 and no stk_push.
//  6. count=5, flush -> exactly 5 stk_pop pulses, each followed by a low cycle; busy high throughout; then count=0 and IDLE.
//     Additionally assert rst during STROBE -> stk_push=0 and count=0 on the next cycle.

Source files
------------

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto a single edge-triggered Stack. It issues isolated one-cycle
// push/pop strobes, tracks occupancy, rejects overflow/underflow and can drain the stack on flush.
module stack_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_op,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    input  logic                flush,
    output logic                busy,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [DATA_W-1:0]   stk_d_in,
    input  logic [DATA_W-1:0]   stk_d_out
);
    // Handshake: a requester holds req_valid (with stable op/data) until its done bit pulses
    // for one cycle; it then drops valid or presents its next op in the following cycle.
    typedef enum logic [2:0] {IDLE, STROBE, RESP, F_STROBE, F_GAP} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic                last_grant, last_grant_nxt;
    logic                id, id_nxt;
    logic                op, op_nxt;
    logic [DATA_W-1:0]   top, top_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic [1:0]          done_nxt;
    logic [DATA_W-1:0]   rsp_data_nxt;
    logic                rsp_err_nxt;
    logic                push_nxt, pop_nxt;
    logic [DATA_W-1:0]   d_in_nxt;
    logic                gnt;
    logic                illegal;

    assign busy  = (state != IDLE);
    assign full  = (count == MAX_CNT);
    assign empty = (count == '0);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        id_nxt         = id;
        op_nxt         = op;
        top_nxt        = top;
        count_nxt      = count;
        done_nxt       = '0;
        rsp_data_nxt   = '0;
        rsp_err_nxt    = 1'b0;
        push_nxt       = 1'b0;
        pop_nxt        = 1'b0;
        d_in_nxt       = stk_d_in;
        gnt            = 1'b0;
        illegal        = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    if (count != '0) begin
                        state_nxt = F_STROBE;
                        pop_nxt   = 1'b1;
                    end
                end else if (req_valid != 2'b00) begin
                    // Round-robin only matters when both compete; a lone requester just wins.
                    if (&req_valid) begin
                        gnt            = ~last_grant;
                        last_grant_nxt = ~last_grant;
                    end else begin
                        gnt = req_valid[1];
                    end
                    id_nxt   = gnt;
                    op_nxt   = req_op[gnt];
                    d_in_nxt = gnt ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    top_nxt  = stk_d_out;
                    illegal  = req_op[gnt] ? (count == '0) : (count == MAX_CNT);
                    if (illegal) begin
                        state_nxt   = RESP;
                        done_nxt    = gnt ? 2'b10 : 2'b01;
                        rsp_err_nxt = 1'b1;
                    end else begin
                        state_nxt = STROBE;
                        push_nxt  = ~req_op[gnt];
                        pop_nxt   = req_op[gnt];
                    end
                end
            end
            STROBE: begin
                count_nxt    = op ? count - 1'b1 : count + 1'b1;
                state_nxt    = RESP;
                done_nxt     = id ? 2'b10 : 2'b01;
                rsp_data_nxt = op ? top : '0;
            end
            RESP: state_nxt = IDLE;
            F_STROBE: begin
                count_nxt = count - 1'b1;
                state_nxt = F_GAP;
            end
            F_GAP: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = F_STROBE;
                    pop_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            op         <= 1'b0;
            top        <= '0;
            count      <= '0;
            done       <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_d_in   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            id         <= id_nxt;
            op         <= op_nxt;
            top        <= top_nxt;
            count      <= count_nxt;
            done       <= done_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_err    <= rsp_err_nxt;
            stk_push   <= push_nxt;
            stk_pop    <= pop_nxt;
            stk_d_in   <= d_in_nxt;
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: a behavioural Stack plus a queue-based reference
// model of the shared stack, directed scenarios and randomized single/contended traffic.
module tb_stack_arbiter;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_op;
    logic [15:0]       req_data;
    logic [1:0]        done;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              flush;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              stk_push;
    logic              stk_pop;
    logic [7:0]        stk_d_in;
    logic [7:0]        stk_d_out;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the stack contents as a queue (back = top), plus round-robin pointer.
    logic [7:0] model_q[$];
    int         model_last = 1;

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err), .flush(flush), .busy(busy),
        .count(count), .full(full), .empty(empty), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_d_in(stk_d_in), .stk_d_out(stk_d_out)
    );

    // Behavioural edge-triggered Stack; slot 0 is never written. Reset re-initialises it.
    logic [7:0] mem [0:DEPTH-1];
    logic [9:0] sp;
    assign stk_d_out = (sp == 10'd0) ? 8'h00 : mem[sp];
    always @(posedge clk) begin
        if (rst) sp <= 10'd0;
        else if (stk_push) begin
            mem[sp + 10'd1] <= stk_d_in;
            sp <= sp + 10'd1;
        end else if (stk_pop) sp <= sp - 10'd1;
    end

    task automatic model_apply(input logic op, input logic [7:0] data,
                               output logic exp_err, output logic [7:0] exp_data);
        exp_err = 1'b0;
        exp_data = 8'h00;
        if (!op) begin
            if (model_q.size() == DEPTH - 1) exp_err = 1'b1;
            else model_q.push_back(data);
        end else begin
            if (model_q.size() == 0) exp_err = 1'b1;
            else exp_data = model_q.pop_back();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; req_op = 2'b00; req_data = 16'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_last = 1;
    endtask

    // Waits (bounded) for a done pulse, counting strobes seen on the way.
    task automatic wait_done(output logic [1:0] d, output logic [7:0] data, output logic err,
                             output int lat, output int pushes, output int pops,
                             output logic [7:0] pushed_val);
        d = 2'b00; data = 8'h00; err = 1'b0; lat = 0; pushes = 0; pops = 0; pushed_val = 8'h00;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (stk_push) begin pushes++; pushed_val = stk_d_in; end
            if (stk_pop) pops++;
            if (done != 2'b00) begin
                d = done; data = rsp_data; err = rsp_err;
                break;
            end
        end
    endtask

    task automatic run_op(input int id, input logic op, input logic [7:0] data,
                          output logic [1:0] d, output logic [7:0] rdata, output logic err,
                          output int lat, output int pushes, output int pops,
                          output logic [7:0] pushed_val);
        @(negedge clk);
        req_op[id] = op;
        req_data[id*8 +: 8] = data;
        req_valid[id] = 1'b1;
        wait_done(d, rdata, err, lat, pushes, pops, pushed_val);
        req_valid[id] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++; if ({done, rsp_err, stk_push, stk_pop, busy} !== 6'b0) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 000000", {done, rsp_err, stk_push, stk_pop, busy}); end
        tests_run++; if (count !== 10'd0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL reset_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
        tests_run++; if (rsp_data !== 8'h00 || stk_d_in !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got rsp_data=%h stk_d_in=%h expected 00/00", rsp_data, stk_d_in); end
    endtask

    task automatic test_push_basic();
        logic [1:0] d; logic [7:0] rd, pv, ed; logic err, ee; int lat, pu, po;
        model_apply(1'b0, 8'hA5, ee, ed);
        run_op(0, 1'b0, 8'hA5, d, rd, err, lat, pu, po, pv);
        tests_run++; if (d !== 2'b01 || lat != 2) begin tests_failed++; $display("FAIL push_done: got done=%b lat=%0d expected 01/2", d, lat); end
        tests_run++; if (pu != 1 || po != 0 || pv !== 8'hA5) begin tests_failed++; $display("FAIL push_strobe: got pushes=%0d pops=%0d d_in=%h expected 1/0/a5", pu, po, pv); end
        tests_run++; if (err !== ee || count !== 10'd1) begin tests_failed++; $display("FAIL push_state: got err=%b count=%0d expected %b/1", err, count, ee); end
    endtask

    task automatic test_lifo();
        logic [1:0] d; logic [7:0] rd, pv, ed; logic err, ee; int lat, pu, po;
        do_reset();
        model_apply(1'b0, 8'h11, ee, ed); run_op(0, 1'b0, 8'h11, d, rd, err, lat, pu, po, pv);
        model_apply(1'b0, 8'h22, ee, ed); run_op(0, 1'b0, 8'h22, d, rd, err, lat, pu, po, pv);
        model_apply(1'b1, 8'h00, ee, ed); run_op(1, 1'b1, 8'h00, d, rd, err, lat, pu, po, pv);
        tests_run++; if (d !== 2'b10 || rd !== ed || err !== ee || po != 1) begin tests_failed++; $display("FAIL lifo_pop1: got done=%b data=%h err=%b pops=%0d expected 10/%h/%b/1", d, rd, err, po, ed, ee); end
        tests_run++; if (count !== 10'd1) begin tests_failed++; $display("FAIL lifo_count1: got %0d expected 1", count); end
        model_apply(1'b1, 8'h00, ee, ed); run_op(1, 1'b1, 8'h00, d, rd, err, lat, pu, po, pv);
        tests_run++; if (rd !== ed || empty !== 1'b1 || count !== 10'd0) begin tests_failed++; $display("FAIL lifo_pop2: got data=%h empty=%b count=%0d expected %h/1/0", rd, empty, count, ed); end
    endtask

    task automatic test_pop_empty();
        logic [1:0] d; logic [7:0] rd, pv, ed; logic err, ee; int lat, pu, po;
        model_apply(1'b1, 8'h00, ee, ed);
        run_op(1, 1'b1, 8'h00, d, rd, err, lat, pu, po, pv);
        tests_run++; if (d !== 2'b10 || err !== 1'b1 || err !== ee) begin tests_failed++; $display("FAIL underflow_err: got done=%b err=%b expected 10/1", d, err); end
        tests_run++; if (rd !== 8'h00 || po != 0 || count !== 10'd0) begin tests_failed++; $display("FAIL underflow_side: got data=%h pops=%0d count=%0d expected 00/0/0", rd, po, count); end
    endtask

    task automatic test_contention();
        logic [1:0] d, exp_d; logic [7:0] rd, pv, ed; logic err, ee; int lat, pu, po, win;
        do_reset();
        req_op = 2'b00; req_data = {8'h20, 8'h10}; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            win = 1 - model_last;
            model_last = win;
            exp_d = (win == 0) ? 2'b01 : 2'b10;
            model_apply(1'b0, req_data[win*8 +: 8], ee, ed);
            wait_done(d, rd, err, lat, pu, po, pv);
            tests_run++; if (d !== exp_d || pv !== req_data[win*8 +: 8]) begin tests_failed++; $display("FAIL rr_grant%0d: got done=%b d_in=%h expected %b/%h", k, d, pv, exp_d, req_data[win*8 +: 8]); end
            req_data[win*8 +: 8] = req_data[win*8 +: 8] + 8'h01;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        tests_run++; if (count !== 10'(model_q.size())) begin tests_failed++; $display("FAIL rr_count: got %0d expected %0d", count, model_q.size()); end
    endtask

    task automatic test_random();
        logic [1:0] d, exp_d; logic [7:0] rd, pv, ed, dat; logic err, ee, op; int lat, pu, po, id;
        logic [1:0] ops; logic [15:0] datas; int win, los;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                ops = 2'($urandom_range(0, 3)); datas = 16'($urandom);
                @(negedge clk);
                req_op = ops; req_data = datas; req_valid = 2'b11;
                win = 1 - model_last; los = model_last; model_last = win;
                for (int s = 0; s < 2; s++) begin
                    id = (s == 0) ? win : los;
                    exp_d = (id == 0) ? 2'b01 : 2'b10;
                    model_apply(ops[id], datas[id*8 +: 8], ee, ed);
                    wait_done(d, rd, err, lat, pu, po, pv);
                    tests_run++; if (d !== exp_d || err !== ee || rd !== ed) begin tests_failed++; $display("FAIL rand_pair%0d_%0d: got done=%b err=%b data=%h expected %b/%b/%h", n, s, d, err, rd, exp_d, ee, ed); end
                    req_valid[id] = 1'b0;
                end
                @(posedge clk); #1;
            end else begin
                id = $urandom_range(0, 1);
                op = ($urandom_range(0, 2) == 0);
                dat = 8'($urandom);
                exp_d = (id == 0) ? 2'b01 : 2'b10;
                model_apply(op, dat, ee, ed);
                run_op(id, op, dat, d, rd, err, lat, pu, po, pv);
                tests_run++; if (d !== exp_d || err !== ee || rd !== ed) begin tests_failed++; $display("FAIL rand_op%0d: got done=%b err=%b data=%h expected %b/%b/%h", n, d, err, rd, exp_d, ee, ed); end
                tests_run++; if (pu != ((!op && !ee) ? 1 : 0) || po != ((op && !ee) ? 1 : 0)) begin tests_failed++; $display("FAIL rand_strobe%0d: got pushes=%0d pops=%0d", n, pu, po); end
            end
            tests_run++; if (count !== 10'(model_q.size())) begin tests_failed++; $display("FAIL rand_count%0d: got %0d expected %0d", n, count, model_q.size()); end
        end
    endtask

    task automatic test_fill();
        logic [1:0] d; logic [7:0] rd, pv, ed; logic err, ee; int lat, pu, po, bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < DEPTH - 2; i++) begin
            model_apply(1'b0, 8'(i), ee, ed);
            run_op(0, 1'b0, 8'(i), d, rd, err, lat, pu, po, pv);
            if (d !== 2'b01 || err !== 1'b0) bad++;
        end
        tests_run++; if (bad != 0 || count !== 10'd1022 || full !== 1'b0) begin tests_failed++; $display("FAIL fill_1022: got bad=%0d count=%0d full=%b expected 0/1022/0", bad, count, full); end
        model_apply(1'b0, 8'hFE, ee, ed);
        run_op(1, 1'b0, 8'hFE, d, rd, err, lat, pu, po, pv);
        tests_run++; if (err !== ee || pu != 1 || full !== 1'b1 || count !== 10'd1023) begin tests_failed++; $display("FAIL fill_last: got err=%b pushes=%0d full=%b count=%0d expected %b/1/1/1023", err, pu, full, count, ee); end
        model_apply(1'b0, 8'h77, ee, ed);
        run_op(0, 1'b0, 8'h77, d, rd, err, lat, pu, po, pv);
        tests_run++; if (err !== 1'b1 || err !== ee || pu != 0 || count !== 10'd1023) begin tests_failed++; $display("FAIL overflow: got err=%b pushes=%0d count=%0d expected 1/0/1023", err, pu, count); end
        model_apply(1'b1, 8'h00, ee, ed);
        run_op(1, 1'b1, 8'h00, d, rd, err, lat, pu, po, pv);
        tests_run++; if (rd !== ed || err !== 1'b0 || full !== 1'b0) begin tests_failed++; $display("FAIL pop_full: got data=%h err=%b full=%b expected %h/0/0", rd, err, full, ed); end
    endtask

    task automatic test_flush();
        logic [1:0] d; logic [7:0] rd, pv, ed; logic err, ee; int lat, pu, po;
        int pops, b2b, idle_early, cyc; logic prev_pop;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            model_apply(1'b0, 8'($urandom), ee, ed);
            run_op(i % 2, 1'b0, model_q[model_q.size()-1], d, rd, err, lat, pu, po, pv);
        end
        @(negedge clk);
        flush = 1'b1;
        pops = 0; b2b = 0; idle_early = 0; cyc = 0; prev_pop = 1'b0;
        do begin
            @(posedge clk); #1;
            flush = 1'b0;
            cyc++;
            if (stk_pop) pops++;
            if (stk_pop && prev_pop) b2b++;
            if (!busy && pops < 5) idle_early++;
            prev_pop = stk_pop;
        end while (busy && cyc < 40);
        model_q.delete();
        tests_run++; if (pops != 5 || b2b != 0) begin tests_failed++; $display("FAIL flush_pops: got pops=%0d back_to_back=%0d expected 5/0", pops, b2b); end
        tests_run++; if (idle_early != 0 || busy !== 1'b0 || cyc != 11) begin tests_failed++; $display("FAIL flush_busy: got early_idle=%0d busy=%b cycles=%0d expected 0/0/11", idle_early, busy, cyc); end
        tests_run++; if (count !== 10'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL flush_count: got count=%0d empty=%b expected 0/1", count, empty); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++; if (busy !== 1'b0 || stk_pop !== 1'b0) begin tests_failed++; $display("FAIL flush_empty: got busy=%b stk_pop=%b expected 0/0", busy, stk_pop); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_op[0] = 1'b0; req_data[7:0] = 8'h5C; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (stk_push !== 1'b1 || stk_d_in !== 8'h5C) begin tests_failed++; $display("FAIL midrst_pre: got stk_push=%b d_in=%h expected 1/5c", stk_push, stk_d_in); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (stk_push !== 1'b0 || count !== 10'd0 || done !== 2'b00 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst: got push=%b count=%0d done=%b busy=%b expected 0/0/00/0", stk_push, count, done, busy); end
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        @(posedge clk); #1;
        tests_run++; if (done !== 2'b00 || count !== 10'd0) begin tests_failed++; $display("FAIL midrst_after: got done=%b count=%0d expected 00/0", done, count); end
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_lifo();
        test_pop_empty();
        test_contention();
        test_random();
        test_fill();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end
endmodule
